// File: rtl/perf_event_counters.sv
// Event-counter bank: NUM_CH event counters plus one free-running cycle
// counter (index NUM_CH). Counting freezes while the processor is halted,
// overflow is sticky per counter, and any counter can be read through a
// registered select port with one cycle of latency.
module perf_event_counters #(
    parameter int NUM_CH   = 6,
    parameter int CNT_W    = 32,
    parameter int SATURATE = 1,
    parameter int SEL_W    = $clog2(NUM_CH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic              halt,
    input  logic [NUM_CH-1:0] event_in,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH:0]   ovf,
    output logic              halted
);

    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] HALTED = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [0:0]       stateReg;
    logic [0:0]       stateNext;
    logic [CNT_W-1:0] cntReg  [0:NUM_CH];
    logic [CNT_W-1:0] cntNext [0:NUM_CH];
    logic [NUM_CH:0]  ovfReg;
    logic [NUM_CH:0]  ovfNext;
    logic [CNT_W-1:0] rdMux;
    logic             countOk;
    logic [NUM_CH:0]  bumpVec;

    // Counting is only allowed while running, enabled and not clearing;
    // the top bit is the cycle counter, which bumps every counting cycle.
    assign countOk = (stateReg == RUN) && en && !clr;
    assign bumpVec = countOk ? {1'b1, event_in} : '0;

    // Next value and sticky overflow for each counter. clr wins over
    // everything; an increment at the top value either sticks or wraps.
    generate
        for (genvar gi = 0; gi <= NUM_CH; gi++) begin : g_cnt
            logic atMax;
            assign atMax = (cntReg[gi] == CNT_MAX);

            assign cntNext[gi] = clr          ? '0 :
                                 !bumpVec[gi] ? cntReg[gi] :
                                 !atMax       ? cntReg[gi] + 1'b1 :
                                 (SATURATE != 0) ? CNT_MAX : '0;

            assign ovfNext[gi] = clr ? 1'b0 : (ovfReg[gi] | (bumpVec[gi] & atMax));
        end
    endgenerate

    // Halt is honoured from RUN regardless of en; only clr returns to RUN.
    always_comb begin
        stateNext = stateReg;
        if (clr) begin
            stateNext = RUN;
        end else if ((stateReg == RUN) && halt) begin
            stateNext = HALTED;
        end
    end

    // Read select: pre-update counter value, zero for out-of-range indices.
    always_comb begin
        rdMux = '0;
        for (int i = 0; i <= NUM_CH; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rdMux = cntReg[i];
            end
        end
    end

    // All state: counters, overflow flags, FSM and the registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= NUM_CH; i++) begin
                cntReg[i] <= '0;
            end
            ovfReg   <= '0;
            stateReg <= RUN;
            rd_data  <= '0;
        end else begin
            for (int i = 0; i <= NUM_CH; i++) begin
                cntReg[i] <= cntNext[i];
            end
            ovfReg   <= ovfNext;
            stateReg <= stateNext;
            rd_data  <= rdMux;
        end
    end

    assign ovf    = ovfReg;
    assign halted = (stateReg == HALTED);

endmodule

// File: tb/tb_perf_event_counters.sv
// Directed bench for perf_event_counters: a 32-bit saturating bank for the
// functional tests, plus 4-bit saturating and 4-bit wrapping banks for the
// overflow tests.
module tb_perf_event_counters;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Bank A: NUM_CH=6, CNT_W=32, SATURATE=1
    logic        rstA = 1'b0, enA = 1'b0, clrA = 1'b0, haltA = 1'b0;
    logic [5:0]  evA  = '0;
    logic [2:0]  selA = '0;
    logic [31:0] rdA;
    logic [6:0]  ovfA;
    logic        haltedA;

    // Bank B: CNT_W=4, SATURATE=1 ; Bank C: CNT_W=4, SATURATE=0
    logic        rstBC = 1'b0;
    logic        enB = 1'b0, clrB = 1'b0, haltB = 1'b0;
    logic [5:0]  evB  = '0;
    logic [2:0]  selB = '0;
    logic [3:0]  rdB;
    logic [6:0]  ovfB;
    logic        haltedB;
    logic        enC = 1'b0, clrC = 1'b0, haltC = 1'b0;
    logic [5:0]  evC  = '0;
    logic [2:0]  selC = '0;
    logic [3:0]  rdC;
    logic [6:0]  ovfC;
    logic        haltedC;

    perf_event_counters #(.NUM_CH(6), .CNT_W(32), .SATURATE(1)) u_a (
        .clk(clk), .rst(rstA), .en(enA), .clr(clrA), .halt(haltA),
        .event_in(evA), .rd_sel(selA), .rd_data(rdA), .ovf(ovfA), .halted(haltedA)
    );

    perf_event_counters #(.NUM_CH(6), .CNT_W(4), .SATURATE(1)) u_b (
        .clk(clk), .rst(rstBC), .en(enB), .clr(clrB), .halt(haltB),
        .event_in(evB), .rd_sel(selB), .rd_data(rdB), .ovf(ovfB), .halted(haltedB)
    );

    perf_event_counters #(.NUM_CH(6), .CNT_W(4), .SATURATE(0)) u_c (
        .clk(clk), .rst(rstBC), .en(enC), .clr(clrC), .halt(haltC),
        .event_in(evC), .rd_sel(selC), .rd_data(rdC), .ovf(ovfC), .halted(haltedC)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // ---- reset state ----
        #1;
        rstA  = 1'b1;
        rstBC = 1'b1;
        #2;
        chk("rst_rd", rdA, 32'd0);
        chk("rst_ovf", 32'(ovfA), 32'd0);
        chk("rst_halted", 32'(haltedA), 32'd0);
        tick();
        tick();
        rstA  = 1'b0;
        rstBC = 1'b0;

        // ---- basic count: ch2 on 5 of 10 cycles ----
        enA = 1'b1;
        for (int i = 0; i < 10; i++) begin
            evA = (i % 2 == 0) ? 6'b000100 : 6'b000000;
            tick();
        end
        enA = 1'b0;
        evA = '0;
        selA = 3'd2; tick(); chk("basic_ch2", rdA, 32'd5);
        selA = 3'd6; tick(); chk("basic_cycle", rdA, 32'd10);
        selA = 3'd7; tick(); chk("basic_sel7", rdA, 32'd0);
        chk("basic_ovf", 32'(ovfA), 32'd0);

        // ---- halt freeze ----
        clrA = 1'b1; enA = 1'b1; tick();
        clrA = 1'b0;
        evA = 6'b000001;
        for (int i = 0; i < 3; i++) tick();
        haltA = 1'b1; tick();
        haltA = 1'b0;
        chk("halt_flag", 32'(haltedA), 32'd1);
        evA = 6'b111111;
        for (int i = 0; i < 20; i++) begin
            haltA = i[0];
            tick();
        end
        haltA = 1'b0;
        selA = 3'd0; tick(); chk("halt_ch0", rdA, 32'd4);
        selA = 3'd6; tick(); chk("halt_cycle", rdA, 32'd4);
        chk("halt_still", 32'(haltedA), 32'd1);
        chk("halt_ovf", 32'(ovfA), 32'd0);

        // ---- clr beats halt, en and events in the same cycle ----
        clrA = 1'b1; haltA = 1'b1; evA = 6'b111111; enA = 1'b1; tick();
        clrA = 1'b0; haltA = 1'b0; evA = '0; enA = 1'b0;
        chk("prio_halted", 32'(haltedA), 32'd0);
        selA = 3'd0; tick(); chk("prio_ch0", rdA, 32'd0);
        selA = 3'd6; tick(); chk("prio_cycle", rdA, 32'd0);

        // ---- en=0 freezes everything ----
        enA = 1'b1; evA = 6'b001000;
        for (int i = 0; i < 9; i++) tick();
        enA = 1'b0; evA = 6'b111111;
        for (int i = 0; i < 7; i++) tick();
        evA = '0;
        selA = 3'd3; tick(); chk("en0_ch3", rdA, 32'd9);
        selA = 3'd6; tick(); chk("en0_cycle", rdA, 32'd9);
        selA = 3'd0; tick(); chk("en0_ch0", rdA, 32'd0);

        // ---- asynchronous reset mid-run ----
        enA = 1'b1; selA = 3'd3; tick();
        chk("arst_pre", rdA, 32'd9);
        #1 rstA = 1'b1;
        #1;
        chk("arst_rd", rdA, 32'd0);
        chk("arst_ovf", 32'(ovfA), 32'd0);
        rstA = 1'b0;
        enA = 1'b0;
        tick(); chk("arst_ch3", rdA, 32'd0);

        // ---- read latency ----
        enA = 1'b1; evA = 6'b010000;
        for (int i = 0; i < 7; i++) tick();
        selA = 3'd4; tick(); chk("lat_first", rdA, 32'd7);
        evA = '0; tick(); chk("lat_second", rdA, 32'd8);
        enA = 1'b0;

        // ---- saturate, 4-bit ----
        enB = 1'b1; evB = 6'b000010;
        for (int i = 0; i < 20; i++) tick();
        enB = 1'b0; evB = '0;
        selB = 3'd1; tick(); chk("sat_ch1", 32'(rdB), 32'd15);
        selB = 3'd6; tick(); chk("sat_cycle", 32'(rdB), 32'd15);
        chk("sat_ovf", 32'(ovfB), 32'h42);

        // ---- wrap, 4-bit ----
        enC = 1'b1; evC = 6'b000001;
        for (int i = 0; i < 18; i++) tick();
        enC = 1'b0; evC = '0;
        selC = 3'd0; tick(); chk("wrap_ch0", 32'(rdC), 32'd2);
        chk("wrap_ovf", 32'(ovfC), 32'h41);
        clrC = 1'b1; tick();
        clrC = 1'b0;
        chk("wrap_clr_ovf", 32'(ovfC), 32'd0);
        chk("wrap_clr_halted", 32'(haltedC), 32'd0);
        tick(); chk("wrap_clr_ch0", 32'(rdC), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/perf_event_counters.md
Name: perf_event_counters

Overview:
Synthesizable, parametrised event-counter bank for the pipelined processor with caches. It counts per-cycle event strobes such as RegWrite, MemWrite, Halt, ICacheReq, ICacheHit, DCacheReq and DCacheHit, and also keeps a free-running cycle count. Counters freeze when the processor halts, and any counter can be read through a registered select port. Hardware keeps the statistics, so sims and FPGA runs no longer need bench-side integer counters.

Parameters:
NUM_CH, 6, number of event channels (>=1)
CNT_W, 32, width of every counter, including the cycle counter (>=2)
SATURATE, 1, 1 = counters stick at max on overflow; 0 = counters wrap to 0
SEL_W, $clog2(NUM_CH+1), read-select width (derived; not overridden)

Ports:
clk  in  1  single clock; all state on posedge
rst  in  1  asynchronous, active-high reset
en  in  1  count enable; when 0, no counter (cycle included) advances
clr  in  1  synchronous clear of all counters, flags and halt state
halt  in  1  processor halt strobe (Halt in MEM/WB)
event_in  in  NUM_CH  per-cycle event strobes, one bit per channel
rd_sel  in  SEL_W  read index; 0..NUM_CH-1 = event channel, NUM_CH = cycle counter
rd_data  out  CNT_W  registered read data
ovf  out  NUM_CH+1  sticky overflow flags; bit NUM_CH = cycle counter
halted  out  1  1 while in state HALTED

Behaviour:
- Reset (async, rst=1): all counters 0, ovf=0, halted=0, rd_data=0, state RUN. Reset mid-count discards all values immediately, without waiting for a clock edge.
- FSM has two states: RUN and HALTED. halted is 1 exactly when the state is HALTED.
- RUN, clr=0, en=1:
  - cycle counter +1 every cycle;
  - channel i +1 in every cycle where event_in[i]=1.
- RUN with halt=1:
  - events in the halt cycle are counted, if en=1, so the halting instruction is included;
  - the state becomes HALTED on that edge;
  - halt is honoured even when en=0.
- HALTED: all counters and ovf are frozen; event_in, halt and en are ignored. Only clr or rst leaves HALTED.
- clr=1 (any state): all counters 0, ovf 0, state RUN on that edge. Events and halt in the clr cycle are not counted. clr has priority over halt, en and event_in.
- Overflow, for a counter at 2^CNT_W-1 that receives an increment:
  - SATURATE=1: the counter holds at 2^CNT_W-1;
  - SATURATE=0: the counter wraps to 0;
  - in both modes the matching ovf bit sets to 1 and stays set until clr or rst.
  - A saturated counter that receives further increments keeps ovf=1 and does not change value.
- Readout: on each posedge, rd_data is loaded with the pre-update value of the selected counter. Latency is 1 cycle, and rd_data does not reflect that edge's increment. If rd_sel > NUM_CH, rd_data is loaded with 0. rd_data updates in every state, HALTED included.
- Arithmetic: plain unsigned CNT_W-bit. Each counter increments by at most 1 per cycle.
- No combinational path from any input to rd_data, ovf or halted.

Test Plan:
- Reset/basic count: NUM_CH=6, CNT_W=32. Release rst, hold en=1, pulse event_in[2] on 5 of 10 cycles. rd_sel=2 then gives 5; rd_sel=6 gives 10; rd_sel=7 gives 0; ovf=0.
- Halt freeze: count 3 events on ch0, then assert halt together with event_in[0]=1. Ch0 reads 4 and halted=1. Drive 20 more cycles of events: ch0 stays 4 and the cycle count stays frozen.
- Saturate: CNT_W=4, SATURATE=1, event_in[1]=1 for 20 cycles. Ch1 reads 15, ovf[1]=1, ovf[6]=1 (cycle counter), other ovf bits 0.
- Wrap: CNT_W=4, SATURATE=0, event_in[0]=1 for 18 cycles. Ch0 reads 2 and ovf[0]=1. After 1 clr cycle: ch0 reads 0, ovf=0, halted=0.
- Priority/enable:
  - Same-cycle clr+halt+event_in=all-ones: all counters 0 and halted=0.
  - en=0 for 7 cycles with events: no counter changes.
  - Assert rst mid-run with ch3=9: rd_data=0 and ch3=0 immediately, before the next edge.
- Read latency: with ch4=7, an event on ch4 and rd_sel=4 in the same cycle give rd_data=7 after that edge and 8 after the next.
